// File: rtl/argmax_pkg.sv
// Shared argmax-stage definitions: result memory geometry and the reader's state encoding.
package argmax_pkg;

    localparam int FEATURE_ROWS          = 6;
    localparam int WEIGHT_COLS           = 3;
    localparam int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS);
    localparam int ARGMAX_WIDTH          = $clog2(WEIGHT_COLS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_PRESENT,
        ST_DONE
    } argmax_reader_state_t;

endpackage

// File: rtl/argmax_result_reader.sv
// Streams the per-row argmax results out of the result memory over valid/ready,
// one read per row, absorbing the single-cycle memory latency.
module argmax_result_reader
    import argmax_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             read_enable,
    output logic [COUNTER_FEATURE_WIDTH-1:0] read_address,
    input  logic [ARGMAX_WIDTH-1:0]          read_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ARGMAX_WIDTH-1:0]          out_data,
    output logic [COUNTER_FEATURE_WIDTH-1:0] out_row,
    output logic                             out_last,
    output logic                             range_error,
    output logic                             done
);

    localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW =
        COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [ARGMAX_WIDTH:0] NUM_CLASSES = (ARGMAX_WIDTH + 1)'(WEIGHT_COLS);

    argmax_reader_state_t             state_q, state_d;
    logic [COUNTER_FEATURE_WIDTH-1:0] counter_q, counter_d;
    logic [ARGMAX_WIDTH-1:0]          data_q, data_d;
    logic                             range_q, range_d;
    logic                             start_q, start_d;
    logic                             rise;
    logic                             capture_bad;

    assign rise        = start & ~start_q;
    // Flagged combinationally so the error is visible in the same cycle the bad word arrives.
    assign capture_bad = (state_q == ST_CAPTURE) && ({1'b0, read_data} >= NUM_CLASSES);

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        data_d    = data_q;
        range_d   = range_q;
        start_d   = start;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (rise) begin
                    state_d   = ST_ISSUE;
                    counter_d = '0;
                    range_d   = 1'b0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                data_d  = read_data;
                range_d = range_q | capture_bad;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    if (counter_q == LAST_ROW) begin
                        state_d = ST_DONE;
                    end else begin
                        counter_d = counter_q + COUNTER_FEATURE_WIDTH'(1);
                        state_d   = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            data_q    <= '0;
            range_q   <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            data_q    <= data_d;
            range_q   <= range_d;
            start_q   <= start_d;
        end
    end

    // Outputs are decoded from state so every idle-side value is zero without extra flops.
    assign read_enable  = (state_q == ST_ISSUE);
    assign read_address = (state_q == ST_ISSUE) ? counter_q : '0;
    assign out_valid    = (state_q == ST_PRESENT);
    assign out_data     = (state_q == ST_PRESENT) ? data_q : '0;
    assign out_row      = (state_q == ST_PRESENT) ? counter_q : '0;
    assign out_last     = (state_q == ST_PRESENT) && (counter_q == LAST_ROW);
    assign range_error  = range_q | capture_bad;
    assign done         = (state_q == ST_DONE);

endmodule
